// File: rtl/hazard_stall_controller_pkg.sv
// hazard_stall_controller_pkg: shared pipeline types and stage-control encodings
package hazard_stall_controller_pkg;
  localparam int REG_AW = 5;
  typedef enum logic {RUN, MD_BUSY} hsc_state_t;
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic exmem_write;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_bubble;
    logic memwb_bubble;
  } stage_ctrl_t;
  localparam stage_ctrl_t CTL_RST = 8'b0000_0000;
  localparam stage_ctrl_t CTL_RUN = 8'b1111_0000;
  localparam stage_ctrl_t CTL_MEMFRZ = 8'b0000_0001;
  localparam stage_ctrl_t CTL_MD = 8'b0001_0010;
  localparam stage_ctrl_t CTL_BR = 8'b1111_1100;
  localparam stage_ctrl_t CTL_LU = 8'b0011_0100;
endpackage

// File: rtl/hazard_stall_controller_wait_timer.sv
// hsc_wait_timer: saturating data-memory wait counter with sticky timeout flag
module hsc_wait_timer #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic freeze,
  output logic timeout
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  logic [WW-1:0] wait_cnt, wait_cnt_n;
  // count consecutive freeze cycles, holding at the limit, clearing on release
  always_comb begin
    wait_cnt_n = !freeze ? '0 : (wait_cnt == WW'(MEM_TIMEOUT)) ? wait_cnt : wait_cnt + 1'b1;
  end
  // register the count; timeout latches once the limit is reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_n;
      timeout <= timeout | (wait_cnt_n == WW'(MEM_TIMEOUT));
    end
  end
endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: pipeline stall/flush sequencer; HAZ_PERF_CNT_EN adds perf counters
module hazard_stall_controller #(
  parameter int REG_AW = hazard_stall_controller_pkg::REG_AW,
  parameter int MD_LAT = 4,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ID_RS,
  input  logic [REG_AW-1:0] ID_RT,
  input  logic              ID_UsesRT,
  input  logic [REG_AW-1:0] EX_RD,
  input  logic              EX_MemRead,
  input  logic              EX_BranchTaken,
  input  logic              EX_MdStart,
  input  logic              MEM_Req,
  input  logic              MEM_Ready,
  output logic              PC_Write,
  output logic              IFID_Write,
  output logic              IDEX_Write,
  output logic              EXMEM_Write,
  output logic              IFID_Flush,
  output logic              IDEX_Bubble,
  output logic              EXMEM_Bubble,
  output logic              MEMWB_Bubble,
  output logic              MD_Busy,
  output logic              MEM_Timeout
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count,
  output logic [15:0]       lu_count
`endif
);
  import hazard_stall_controller_pkg::*;
  localparam int CW = $clog2(MD_LAT);
  hsc_state_t state, state_n;
  logic [CW-1:0] md_cnt, md_cnt_n;
  logic md_hold, md_hold_n, memfrz, md_go, mdstall, lu;
  stage_ctrl_t ctl;
  assign memfrz = MEM_Req & ~MEM_Ready;
  assign md_go = (state == RUN) & EX_MdStart & ~md_hold;
  assign mdstall = (state == MD_BUSY) | md_go;
  assign lu = EX_MemRead & (EX_RD != '0) & ((EX_RD == ID_RS) | (ID_UsesRT & (EX_RD == ID_RT)));
  // prioritised stage control; everything idles while reset is held
  always_comb begin
    ctl = !rst_n ? CTL_RST : memfrz ? CTL_MEMFRZ : mdstall ? CTL_MD :
          EX_BranchTaken ? CTL_BR : lu ? CTL_LU : CTL_RUN;
  end
  assign PC_Write = ctl.pc_write;
  assign IFID_Write = ctl.ifid_write;
  assign IDEX_Write = ctl.idex_write;
  assign EXMEM_Write = ctl.exmem_write;
  assign IFID_Flush = ctl.ifid_flush;
  assign IDEX_Bubble = ctl.idex_bubble;
  assign EXMEM_Bubble = ctl.exmem_bubble;
  assign MEMWB_Bubble = ctl.memwb_bubble;
  assign MD_Busy = (state == MD_BUSY);
  // mul/div sequencing: count down the latency, then hold off re-trigger until EX advances
  always_comb begin
    state_n = state;
    md_cnt_n = md_cnt;
    md_hold_n = md_hold;
    if (md_go) begin
      state_n = MD_BUSY;
      md_cnt_n = CW'(MD_LAT - 1);
    end
    if (state == MD_BUSY) begin
      md_cnt_n = md_cnt - 1'b1;
      if (md_cnt == CW'(1)) begin
        state_n = RUN;
        md_hold_n = 1'b1;
      end
    end else if (md_hold && !memfrz) begin
      md_hold_n = 1'b0;
    end
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      md_cnt <= '0;
      md_hold <= 1'b0;
    end else begin
      state <= state_n;
      md_cnt <= md_cnt_n;
      md_hold <= md_hold_n;
    end
  end
  hsc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk(clk),
    .rst_n(rst_n),
    .freeze(memfrz),
    .timeout(MEM_Timeout)
  );
`ifdef HAZ_PERF_CNT_EN
  logic lu_bubble;
  assign lu_bubble = ~memfrz & ~mdstall & ~EX_BranchTaken & lu;
  // saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count <= '0;
      lu_count <= '0;
    end else begin
      stall_cycles <= stall_cycles + 32'(~ctl.pc_write & ~&stall_cycles);
      flush_count <= flush_count + 32'(ctl.ifid_flush & ~&flush_count);
      lu_count <= lu_count + 16'(lu_bubble & ~&lu_count);
    end
  end
`endif
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: scoreboard bench for the stall/flush sequencer
module tb_hazard_stall_controller;
  localparam logic [7:0] E_RUN = 8'hF0, E_FRZ = 8'h01, E_MD = 8'h12, E_BR = 8'hFC, E_LU = 8'h34;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic id_uses_rt = 1'b0, ex_mem_read = 1'b0, ex_br = 1'b0, ex_md = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_b, exmem_b, memwb_b, md_busy, mem_to;
  logic [9:0] obs;
  int n_checks = 0, n_fail = 0;
  string tag_q[$];
  logic [9:0] exp_q[$];
  always #5 clk = ~clk;
  hazard_stall_controller #(.REG_AW(5), .MD_LAT(4), .MEM_TIMEOUT(3)) dut (
    .clk(clk), .rst_n(rst_n), .ID_RS(id_rs), .ID_RT(id_rt), .ID_UsesRT(id_uses_rt),
    .EX_RD(ex_rd), .EX_MemRead(ex_mem_read), .EX_BranchTaken(ex_br), .EX_MdStart(ex_md),
    .MEM_Req(mem_req), .MEM_Ready(mem_ready), .PC_Write(pc_w), .IFID_Write(ifid_w),
    .IDEX_Write(idex_w), .EXMEM_Write(exmem_w), .IFID_Flush(ifid_f), .IDEX_Bubble(idex_b),
    .EXMEM_Bubble(exmem_b), .MEMWB_Bubble(memwb_b), .MD_Busy(md_busy), .MEM_Timeout(mem_to)
  );
  assign obs = {pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_b, exmem_b, memwb_b, md_busy, mem_to};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got[9:0], exp[9:0]);
    end
  endtask
  task automatic drive(input string tag, input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                       input logic [4:0] rd, input logic mr, input logic br, input logic md,
                       input logic req, input logic rdy, input logic [7:0] ctl, input logic busy,
                       input logic to);
    @(posedge clk);
    #1;
    id_rs = rs; id_rt = rt; id_uses_rt = ut; ex_rd = rd; ex_mem_read = mr;
    ex_br = br; ex_md = md; mem_req = req; mem_ready = rdy;
    tag_q.push_back(tag);
    exp_q.push_back({ctl, busy, to});
  endtask
  always @(negedge clk) begin
    if (exp_q.size() != 0) check(tag_q.pop_front(), 32'(obs), 32'(exp_q.pop_front()));
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    #3 check("reset_outputs", 32'(obs), 32'd0);
    #9 rst_n = 1'b1;
    drive("lu_rs", 8, 0, 0, 8, 1, 0, 0, 0, 0, E_LU, 0, 0);
    drive("lu_clear", 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 0);
    drive("lu_rd0", 0, 0, 0, 0, 1, 0, 0, 0, 0, E_RUN, 0, 0);
    drive("lu_rt", 3, 9, 1, 9, 1, 0, 0, 0, 0, E_LU, 0, 0);
    drive("lu_rt_unused", 3, 9, 0, 9, 1, 0, 0, 0, 0, E_RUN, 0, 0);
    drive("branch_over_lu", 8, 0, 0, 8, 1, 1, 0, 0, 0, E_BR, 0, 0);
    drive("md_t0", 0, 0, 0, 0, 0, 0, 1, 0, 0, E_MD, 0, 0);
    drive("md_t1", 0, 0, 0, 0, 0, 0, 1, 0, 0, E_MD, 1, 0);
    drive("md_t2", 0, 0, 0, 0, 0, 0, 1, 0, 0, E_MD, 1, 0);
    drive("md_t3", 0, 0, 0, 0, 0, 0, 1, 0, 0, E_MD, 1, 0);
    drive("md_advance", 0, 0, 0, 0, 0, 0, 1, 0, 0, E_RUN, 0, 0);
    drive("md_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 0);
    drive("md2_t0", 0, 0, 0, 0, 0, 0, 1, 0, 0, E_MD, 0, 0);
    drive("md2_t1", 0, 0, 0, 0, 0, 0, 1, 0, 0, E_MD, 1, 0);
    drive("md2_t2", 0, 0, 0, 0, 0, 0, 1, 0, 0, E_MD, 1, 0);
    drive("md2_t3", 0, 0, 0, 0, 0, 0, 1, 0, 0, E_MD, 1, 0);
    drive("md2_frz_at_adv", 0, 0, 0, 0, 0, 0, 1, 1, 0, E_FRZ, 0, 0);
    drive("md2_no_retrig", 0, 0, 0, 0, 0, 0, 1, 0, 0, E_RUN, 0, 0);
    drive("md2_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 0);
    drive("wait1", 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ, 0, 0);
    drive("wait2", 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ, 0, 0);
    drive("wait3", 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ, 0, 0);
    drive("wait_ready", 0, 0, 0, 0, 0, 0, 0, 1, 1, E_RUN, 0, 1);
    drive("timeout_sticky", 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 1);
    drive("br_in_frz", 0, 0, 0, 0, 0, 1, 0, 1, 0, E_FRZ, 0, 1);
    drive("br_after_frz", 0, 0, 0, 0, 0, 1, 0, 1, 1, E_BR, 0, 1);
    drive("post_br", 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 1);
    drive("md_entry_in_frz", 0, 0, 0, 0, 0, 0, 1, 1, 0, E_FRZ, 0, 1);
    drive("md_over_branch", 0, 0, 0, 0, 0, 1, 1, 0, 0, E_MD, 1, 1);
    @(negedge clk);
    @(posedge clk);
    #1 check("md_cnt2_busy", 32'(obs), 32'({E_MD, 1'b1, 1'b1}));
    rst_n = 1'b0;
    ex_md = 1'b0;
    ex_br = 1'b0;
    #1 check("reset_mid_md", 32'(obs), 32'd0);
    #2 rst_n = 1'b1;
    drive("after_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 0);
    @(negedge clk);
    #1 check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
